// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: ALU func codes, FSM encoding, stats width.
package alu_arb_pkg;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_NOR   = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_LUI   = 3'd6;
  localparam logic [2:0] ALU_UNDEF = 3'd7;

  localparam int STAT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester above last_grant wins, with wrap.
// Latency 0; no backpressure of its own, grant is all-zero when nothing requests.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int idx;

  // Scan from the farthest offset down so the nearest valid requester overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU; 2 cycles from accept to rsp_valid, 1 op / 3 cycles.
// Requesters are held off (req_ready=0) until the response is taken; ALU_ARB_STATS_EN adds grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_func,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_func,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic [ID_W-1:0]          rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [NUM_REQ*STAT_CNT_W-1:0] grant_cnt
`endif
);

  arb_state_t        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        func_q, func_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign accept    = (state_q == IDLE) && (|grant);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    func_d       = func_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = req_a[int'(grant_idx)*WIDTH +: WIDTH];
          b_d          = req_b[int'(grant_idx)*WIDTH +: WIDTH];
          func_d       = req_func[int'(grant_idx)*3 +: 3];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_zero_d  = alu_zero;
        rsp_err_d   = (func_q == ALU_UNDEF);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      func_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      func_q       <= func_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_func  = func_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [STAT_CNT_W-1:0] cnt_q [NUM_REQ];
  logic [STAT_CNT_W-1:0] cnt_d [NUM_REQ];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (accept && grant[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*STAT_CNT_W +: STAT_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; expected responses queued at grant, checked by a monitor.
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 1;

  typedef struct packed {
    logic [31:0] d;
    logic        z;
    logic        e;
    logic [0:0]  id;
  } rsp_t;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         a0, b0, a1, b1;
  logic [2:0]               f0, f1;
  logic [WIDTH-1:0]         alu_a, alu_b, alu_out;
  logic [2:0]               alu_func;
  logic                     alu_zero;
  logic                     rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
`ifdef ALU_ARB_STATS_EN
  logic                     stats_clr;
  logic [NUM_REQ*16-1:0]    grant_cnt;
`endif

  int   total = 0;
  int   bad   = 0;
  rsp_t exp_q[$];

  alu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     ({a1, a0}),
    .req_b     ({b1, b0}),
    .req_func  ({f1, f0}),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .rsp_id    (rsp_id)
`ifdef ALU_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  // Behavioural ALU: unsigned SLT, func 6 = b<<16, func 7 returns 0.
  always_comb begin
    alu_out = '0;
    case (alu_func)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = ~(alu_a | alu_b);
      3'd5: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      3'd6: alu_out = alu_b << 16;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got data %0h id %0d expected no response", rsp_data, rsp_id);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.d));
        chk("rsp_zero", 64'(rsp_zero), 64'(e.z));
        chk("rsp_err",  64'(rsp_err),  64'(e.e));
        chk("rsp_id",   64'(rsp_id),   64'(e.id));
      end
    end
  end

  // Wait for a grant, check which requester got it, optionally queue the expected response.
  task automatic wait_grant(input string nm, input logic [1:0] exp_rdy, input logic [31:0] d,
                            input logic z, input logic e, input logic id, input bit push,
                            output int waited);
    int n;
    rsp_t r;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(req_ready), 64'(exp_rdy));
    if (push) begin
      r.d = d; r.z = z; r.e = e; r.id = id;
      exp_q.push_back(r);
    end
    waited = n;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; f0 = '0; a1 = '0; b1 = '0; f1 = '0;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data",  64'(rsp_data),  64'd0);
    chk("reset_rsp_flags", 64'({rsp_zero, rsp_err, rsp_id}), 64'd0);
    chk("reset_alu_in",    64'({alu_a, alu_func}), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First op: SUB 5-3 on requester 0, granted in the same cycle, response two cycles later.
    rsp_ready = 1'b1;
    req_valid = 2'b01; a0 = 32'd5; b0 = 32'd3; f0 = 3'd1;
    wait_grant("first_grant", 2'b01, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, w);
    chk("first_grant_same_cycle", 64'(w), 64'd0);
    req_valid = '0;
    @(negedge clk);
    chk("latency_exec_no_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("latency_resp_valid", 64'(rsp_valid), 64'd1);
    drain();

    // Undefined func is forwarded; the ALU yields zero.
    req_valid = 2'b01; a0 = 32'd9; b0 = 32'd9; f0 = 3'd7;
    wait_grant("undef_grant", 2'b01, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, w);
    req_valid = '0;
    drain();

    // Stall: response held for 5 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    req_valid = 2'b01; a0 = 32'd12; b0 = 32'd10; f0 = 3'd2;
    wait_grant("stall_grant0", 2'b01, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1, w);
    req_valid = 2'b10; a1 = 32'd3; b1 = 32'd4; f1 = 3'd3;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_arrives", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_data",  64'(rsp_data), 64'd8);
      chk("stall_rsp_id",    64'(rsp_id), 64'd0);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_grant("resume_grant1", 2'b10, 32'd7, 1'b0, 1'b0, 1'b1, 1'b1, w);
    chk("resume_next_cycle", 64'(w), 64'd1);
    req_valid = '0;
    drain();

    // Both requesters valid throughout: grants alternate starting with 0.
    req_valid = 2'b11;
    a0 = 32'd7; b0 = 32'd7; f0 = 3'd1;
    a1 = 32'd1; b1 = 32'd2; f1 = 3'd5;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        wait_grant("alt_grant_req0", 2'b01, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, w);
      else
        wait_grant("alt_grant_req1", 2'b10, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, w);
    end
    req_valid = '0;
    drain();

    // Reset during EXEC: no response, outputs cleared, requester 0 wins afterwards.
    req_valid = 2'b10; a1 = 32'd1; b1 = 32'd1; f1 = 3'd0;
    wait_grant("rst_pre_grant", 2'b10, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, w);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_alu_in",    64'({alu_a, alu_b, alu_func}), 64'd0);
    chk("midrst_rsp_out",   64'({rsp_data, rsp_zero, rsp_err, rsp_id}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_response", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b11; a0 = 32'd20; b0 = 32'd6; f0 = 3'd1;
    wait_grant("post_rst_grant0", 2'b01, 32'd14, 1'b0, 1'b0, 1'b0, 1'b1, w);
    req_valid = '0;
    drain();

`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    a1 = 32'd2; b1 = 32'd2; f1 = 3'd0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b10;
      wait_grant("stats_grant1", 2'b10, 32'd4, 1'b0, 1'b0, 1'b1, 1'b1, w);
      req_valid = '0;
      drain();
    end
    chk("stats_cnt1_three", 64'(grant_cnt[31:16]), 64'd3);
    req_valid = 2'b10;
    stats_clr = 1'b1;
    @(negedge clk);
    chk("stats_clr_grant", 64'(req_ready), 64'(2'b10));
    exp_q.push_back('{d: 32'd4, z: 1'b0, e: 1'b0, id: 1'b1});
    @(posedge clk); #1;
    stats_clr = 1'b0;
    req_valid = '0;
    chk("stats_clr_priority", 64'(grant_cnt), 64'd0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
